seven_seg_reader: RTL and testbench
===================================

SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter: STABLE_CYC, default 4, number of consecutive identical samples required before a digit is captured (legal range 2..15).
REQ-002 Port: clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, reset is synchronous and active-high.
REQ-004 Port: seg, input, 7, active-low segment bus, seg[0]=a through seg[6]=g.
REQ-005 Port: an, input, 2, active-low digit enables; an=2'b10 selects digit0, an=2'b01 selects digit1.
REQ-006 Port: digit0, output, 4, last captured hex value of digit0.
REQ-007 Port: digit1, output, 4, last captured hex value of digit1.
REQ-008 Port: valid, output, 1, high once both digits have been captured since reset.
REQ-009 Port: upd, output, 1, one-cycle pulse when a capture changes digit0 or digit1.
REQ-010 Port: err, output, 1, one-cycle pulse when a stable pattern is not a hex glyph or blank.
REQ-011 Port: err_cnt, output, 8, saturating count of err pulses since reset.

Function
REQ-012 The block shall register an and seg in one input stage before any other use.
REQ-013 The FSM shall have states IDLE, TRACK and HELD.
REQ-014 IDLE: when an is 2'b00 or 2'b11, the FSM shall stay in or return to IDLE and clear the stability counter.
REQ-015 IDLE->TRACK on a legal an; in TRACK, each registered sample equal to the previous one ({an,seg}) shall increment the counter, and any difference shall reload the counter to 1.
REQ-016 When the counter reaches STABLE_CYC, the FSM shall capture once and enter HELD; for input held from the first sampling edge (edge 1), outputs shall update at edge STABLE_CYC+1.
REQ-017 HELD shall perform no further capture until {an,seg} changes, then go to TRACK (counter=1), or to IDLE if an is illegal.
REQ-018 Capture of a hex glyph (0-9, A, b, C, d, E, F in standard 7-seg form) shall write the decoded nibble to the selected digit and set that digit's seen flag.
REQ-019 upd shall pulse at capture only if the written nibble differs from the held value or the digit was not previously seen.
REQ-020 A blank pattern (7'b1111111) shall be ignored: no write, no err.
REQ-021 Any other pattern shall pulse err, increment err_cnt (saturating at 8'hFF), and leave the digits unchanged.
REQ-022 valid shall equal seen0 AND seen1.
REQ-023 On a simultaneous capture and counter saturation, err_cnt shall hold at 8'hFF while err still pulses.

Reset
REQ-024 When reset=1 at a rising edge: the FSM shall go to IDLE; the counter, input registers (an=2'b11, seg=7'h7F), digit0, digit1, seen flags, valid, upd, err and err_cnt shall clear to 0.
REQ-025 Reset shall take priority over every other event, including a capture in the same cycle; any in-progress tracking shall be discarded.

Structure
REQ-026 A shared package seven_seg_pkg shall hold the FSM state typedef, the 16 glyph constants and the blank constant.
REQ-027 A combinational sub-module seg_to_hex (input seg[6:0]; outputs nibble[3:0], is_hex, is_blank) shall perform the decode, and the top level shall instantiate it once.

Verification
REQ-028 Scenario: reset, then an=2'b10, seg=7'b1111001 for 4 cycles -> after edge 5, digit0=4'h1, upd=1 for one cycle, valid=0.
REQ-029 Scenario: then an=2'b01, seg=7'b0001000 for 4 cycles -> digit1=4'hA, upd pulse, valid=1.
REQ-030 Scenario: seg=7'b0100100 held 3 cycles on digit0, then changed -> no capture, digit0 unchanged, no upd.
REQ-031 Scenario: seg=7'b0110110 stable 4 cycles -> err pulse, err_cnt=1, digits unchanged; 256 such events -> err_cnt=8'hFF.
REQ-032 Scenario: an=2'b00 or 2'b11 with a stable glyph for 10 cycles -> no capture; the same glyph re-captured with the same value -> no upd.
REQ-033 Scenario: reset asserted at cycle 3 of tracking -> all outputs 0 after that edge, and a fresh 4-cycle hold is required afterwards.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and glyph constants for the seven-segment display reader.
// Glyphs are active-low, bit 0 = segment a through bit 6 = segment g.
package seven_seg_pkg;

  typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational decode of an active-low segment pattern into a hex nibble,
// flagging whether the pattern is a legal hex glyph or an all-off blank.
module seg_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    nibble   = 4'h0;
    is_hex   = 1'b1;
    is_blank = (seg == GLYPH_BLANK);
    case (seg)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Snoops a 2-digit multiplexed seven-segment bus and recovers the hex digits,
// capturing a digit once its {an,seg} sample has been stable for STABLE_CYC cycles.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [1:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       valid,
  output logic       upd,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYC);

  state_t     r_state;
  logic [1:0] r_an, r_prev_an;
  logic [6:0] r_seg, r_prev_seg;
  logic [3:0] r_cnt;
  logic [3:0] r_digit0, r_digit1;
  logic       r_seen0, r_seen1;
  logic       r_upd, r_err;
  logic [7:0] r_err_cnt;

  logic [3:0] w_nib;
  logic       w_hex, w_blank, w_legal, w_same;
  logic [3:0] w_cnt_inc;

  seg_to_hex u_dec (
    .seg      (r_seg),
    .nibble   (w_nib),
    .is_hex   (w_hex),
    .is_blank (w_blank)
  );

  assign w_legal   = (r_an == 2'b10) || (r_an == 2'b01);
  assign w_same    = ({r_an, r_seg} == {r_prev_an, r_prev_seg});
  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_an       <= 2'b11;
      r_seg      <= 7'h7F;
      r_prev_an  <= 2'b11;
      r_prev_seg <= 7'h7F;
      r_cnt      <= 4'd0;
      r_digit0   <= 4'h0;
      r_digit1   <= 4'h0;
      r_seen0    <= 1'b0;
      r_seen1    <= 1'b0;
      r_upd      <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= 8'h00;
    end else begin
      r_an       <= an;
      r_seg      <= seg;
      // Previous sample only feeds the stability compare, so track it every cycle.
      r_prev_an  <= r_an;
      r_prev_seg <= r_seg;
      r_upd      <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_legal) begin
            r_state <= TRACK;
            r_cnt   <= 4'd1;
          end else begin
            r_cnt   <= 4'd0;
          end
        end
        TRACK: begin
          if (!w_legal) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end else if (!w_same) begin
            r_cnt   <= 4'd1;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == STABLE) begin
              r_state <= HELD;
              if (w_hex) begin
                if (r_an == 2'b10) begin
                  r_upd    <= !r_seen0 || (r_digit0 != w_nib);
                  r_digit0 <= w_nib;
                  r_seen0  <= 1'b1;
                end else begin
                  r_upd    <= !r_seen1 || (r_digit1 != w_nib);
                  r_digit1 <= w_nib;
                  r_seen1  <= 1'b1;
                end
              end else if (!w_blank) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              end
            end
          end
        end
        HELD: begin
          if (!w_same) begin
            r_state <= w_legal ? TRACK : IDLE;
            r_cnt   <= w_legal ? 4'd1 : 4'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign digit0  = r_digit0;
  assign digit1  = r_digit1;
  assign valid   = r_seen0 & r_seen1;
  assign upd     = r_upd;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Scoreboard bench: each hold that should capture pushes the expected pulse
// state; a negedge monitor pops and compares whenever upd or err fires.
module tb_seven_seg_reader;

  localparam int S = 4;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d0;
    logic       vld;
    logic       upd;
    logic       err;
    logic [7:0] ec;
  } exp_t;

  logic       clk, reset;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] digit0, digit1;
  logic       valid, upd, err;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;
  exp_t q[$];

  logic [6:0] glyph [16];
  logic [8:0] m_key;
  int         m_run;
  logic       m_done;
  logic [3:0] m_d0, m_d1;
  logic       m_seen0, m_seen1;
  logic [7:0] m_ec;

  seven_seg_reader #(.STABLE_CYC(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an),
    .digit0(digit0), .digit1(digit1), .valid(valid),
    .upd(upd), .err(err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_key = 9'h1FF; m_run = 0; m_done = 1'b0;
    m_d0 = 4'h0; m_d1 = 4'h0; m_seen0 = 1'b0; m_seen1 = 1'b0; m_ec = 8'h00;
  endtask

  task automatic expect_capture(input logic [1:0] a, input logic [6:0] s);
    exp_t e;
    int   idx = -1;
    logic u;
    for (int i = 0; i < 16; i++) if (glyph[i] == s) idx = i;
    if (idx >= 0) begin
      if (a == 2'b10) begin
        u = !m_seen0 || (m_d0 != 4'(idx)); m_d0 = 4'(idx); m_seen0 = 1'b1;
      end else begin
        u = !m_seen1 || (m_d1 != 4'(idx)); m_d1 = 4'(idx); m_seen1 = 1'b1;
      end
      if (!u) return;
      e = '{d1: m_d1, d0: m_d0, vld: m_seen0 & m_seen1, upd: 1'b1, err: 1'b0, ec: m_ec};
      q.push_back(e);
    end else if (s != 7'h7F) begin
      if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      e = '{d1: m_d1, d0: m_d0, vld: m_seen0 & m_seen1, upd: 1'b0, err: 1'b1, ec: m_ec};
      q.push_back(e);
    end
  endtask

  task automatic hold(input logic [1:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    if ({a, s} == m_key) m_run += n;
    else begin m_key = {a, s}; m_run = n; m_done = 1'b0; end
    if (!m_done && m_run >= S && (a == 2'b10 || a == 2'b01)) begin
      m_done = 1'b1;
      expect_capture(a, s);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_outs", 32'({digit1, digit0, valid, upd, err, err_cnt}), 32'd0);
    reset = 1'b0;
    model_clear();
  endtask

  always @(negedge clk) begin
    if (upd || err) begin
      if (q.size() == 0) chk("unexpected_pulse", 32'({upd, err}), 32'd0);
      else chk("pulse", 32'({digit1, digit0, valid, upd, err, err_cnt}), 32'(q.pop_front()));
    end
  end

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    an = 2'b11; seg = 7'h7F; reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk); #1;
    chk("reset_state", 32'({digit1, digit0, valid, upd, err, err_cnt}), 32'd0);
    reset = 1'b0;

    // digit0 = 1, then digit1 = A
    hold(2'b10, 7'b1111001, 4);
    hold(2'b10, 7'b1111001, 2);
    chk("d0_after_1", 32'({digit0, valid}), 32'({4'h1, 1'b0}));
    hold(2'b01, 7'b0001000, 4);
    hold(2'b01, 7'b0001000, 2);
    chk("d1_after_A", 32'({digit1, valid}), 32'({4'hA, 1'b1}));

    // One cycle short of stable, then a blank: nothing changes
    hold(2'b10, 7'b0100100, 3);
    hold(2'b10, 7'h7F, 5);
    chk("short_hold_d0", 32'(digit0), 32'h1);

    // Non-glyph pattern raises err
    hold(2'b10, 7'b0110110, 4);
    hold(2'b10, 7'h7F, 2);
    chk("err_cnt_1", 32'({err_cnt, digit0, digit1}), 32'({8'd1, 4'h1, 4'hA}));

    // Illegal enables never capture; re-capturing the same value is silent
    hold(2'b00, 7'b0100100, 10);
    hold(2'b11, 7'b0100100, 10);
    chk("illegal_an_d0", 32'(digit0), 32'h1);
    hold(2'b10, 7'b1111001, 6);
    chk("recapture_d0", 32'(digit0), 32'h1);
    hold(2'b10, 7'b0100100, 4);
    hold(2'b10, 7'b0100100, 2);
    chk("d0_after_2", 32'(digit0), 32'h2);

    // Reset mid-tracking discards progress; a full fresh hold is needed
    hold(2'b01, 7'h0E, 3);
    do_reset();
    hold(2'b01, 7'h0E, 3);
    hold(2'b01, 7'h7F, 2);
    chk("post_rst_nocap", 32'({digit1, valid}), 32'd0);
    hold(2'b01, 7'h0E, 4);
    hold(2'b01, 7'h0E, 2);
    chk("post_rst_cap", 32'({digit1, digit0, valid}), 32'({4'hF, 4'h0, 1'b0}));

    // err_cnt saturates while err keeps pulsing
    for (int i = 0; i < 258; i++) begin
      hold(2'b10, 7'b0110110, 4);
      hold(2'b10, 7'h7F, 1);
    end
    hold(2'b10, 7'h7F, 3);
    chk("err_cnt_sat", 32'(err_cnt), 32'hFF);
    chk("digits_after_err", 32'({digit1, digit0}), 32'({4'hF, 4'h0}));
    chk("pending", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
